sd_block_buffer: RTL and testbench

Ping-pong block buffer that sits directly downstream of the SD card SPI reader. It captures the reader's byte stream (one-cycle `data_valid`-style strobes) into two BLOCK_BYTES-deep banks and hands each completed block to a random-access consumer through a ready/release handshake. While the consumer works on one bank, the next SD block fills the other. A block that arrives with no free bank is discarded whole and flagged.

---
 rtl/sd_block_buffer_if.sv | 27 ++
 rtl/sd_block_buffer.sv | 129 ++++++++++++
 tb/tb_sd_block_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_buffer_if.sv
// Bus between the SD reader, the ping-pong block buffer and the block consumer.
// The buffer uses the slave modport; whatever drives bytes and reads blocks uses master.
interface sd_block_buffer_if #(
    parameter int AW = 9
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          abort;
    logic          blk_ready;
    logic          blk_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          blk_done;
    logic          overflow;

    modport master (
        output in_data, in_valid, abort, rd_en, rd_addr, blk_done,
        input  blk_ready, blk_bank, rd_data, rd_valid, overflow
    );

    modport slave (
        input  in_data, in_valid, abort, rd_en, rd_addr, blk_done,
        output blk_ready, blk_bank, rd_data, rd_valid, overflow
    );
endinterface

// File: rtl/sd_block_buffer.sv
// Ping-pong block buffer: fills two BLOCK_BYTES banks from the SD byte stream and
// presents completed blocks to a random-access consumer; blocks with no free bank are dropped.
module sd_block_buffer #(
    parameter int BLOCK_BYTES = 512,
    parameter int AW          = $clog2(BLOCK_BYTES)
) (
    input logic              clk,
    input logic              rst,
    sd_block_buffer_if.slave bus
);
    typedef enum logic {FILL, DROP} wstate_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(BLOCK_BYTES - 1);

    logic [7:0]    mem [0:2*BLOCK_BYTES-1];
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_ptr;
    wstate_t       wstate;
    wstate_t       wstate_next;

    logic          byte_in;
    logic          start_blocked;
    logic          release_bank;
    logic          mem_we;
    logic          ptr_inc;
    logic          set_full;
    logic          set_overflow;

    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          overflow_q;

    // The start check sees full[] before any same-edge release, so a coincident blk_done cannot rescue the block.
    assign byte_in       = bus.in_valid && !bus.abort;
    assign start_blocked = (wr_ptr == '0) && full[wr_bank];
    assign release_bank  = bus.blk_done && full[rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= FILL;
        end else begin
            wstate <= wstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        if (bus.abort) begin
            wstate_next = FILL;
        end else if (bus.in_valid) begin
            case (wstate)
                FILL:    if (start_blocked) wstate_next = DROP;
                DROP:    if (wr_ptr == LAST_PTR) wstate_next = FILL;
                default: wstate_next = FILL;
            endcase
        end
    end

    always_comb begin
        mem_we       = 1'b0;
        ptr_inc      = 1'b0;
        set_full     = 1'b0;
        set_overflow = 1'b0;
        if (byte_in) begin
            ptr_inc = 1'b1;
            case (wstate)
                FILL: begin
                    if (start_blocked) begin
                        set_overflow = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        set_full = (wr_ptr == LAST_PTR);
                    end
                end
                default: ;
            endcase
        end
    end

    // Release and completion always target different banks: a bank cannot fill while it is still full.
    always_comb begin
        full_next = full;
        if (release_bank) full_next[rd_bank] = 1'b0;
        if (set_full)     full_next[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 2'b00;
            wr_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_bank    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full <= full_next;
            if (bus.abort) begin
                wr_ptr <= '0;
            end else if (ptr_inc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (set_full)     wr_bank    <= ~wr_bank;
            if (release_bank) rd_bank    <= ~rd_bank;
            if (set_overflow) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[{wr_bank, wr_ptr}] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= mem[{rd_bank, bus.rd_addr}];
        end
    end

    assign bus.blk_ready = full[rd_bank];
    assign bus.blk_bank  = rd_bank;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_sd_block_buffer.sv
// Self-checking bench for sd_block_buffer: block fills, ping-pong release, overflow drop,
// abort, asynchronous reset and coincident release/fill; reads are checked through a scoreboard queue.
module tb_sd_block_buffer;
    localparam int BLOCK_BYTES = 512;
    localparam int AW          = 9;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         tests    = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       mon_expect;
    logic [7:0] mon_data;
    rd_vec_t    single_vecs[7];

    sd_block_buffer_if #(.AW(AW)) bus();

    sd_block_buffer #(.BLOCK_BYTES(BLOCK_BYTES), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every rd_en seen at an edge must produce rd_valid after it, carrying the oldest queued byte.
    always @(posedge clk) begin
        mon_expect = bus.rd_en && !rst;
        #2;
        if (!rst) begin
            if (mon_expect || bus.rd_valid) check_output("rd_valid", bus.rd_valid, mon_expect);
            if (mon_expect) begin
                if (exp_q.size() == 0) begin
                    check_output("rd_scoreboard_empty", exp_q.size(), 1);
                end else begin
                    mon_data = exp_q.pop_front();
                    check_output("rd_data", bus.rd_data, mon_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] value, input int count,
                                  input bit incrementing, input bit done_on_last);
        for (int i = 0; i < count; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = incrementing ? value + 8'(i) : value;
            bus.blk_done = done_on_last && (i == count - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.blk_done = 1'b0;
    endtask

    task automatic pulse_done();
        bus.blk_done = 1'b1;
        tick();
        bus.blk_done = 1'b0;
    endtask

    task automatic read_byte(input int addr, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        exp_q.push_back(exp);
        tick();
    endtask

    task automatic drain();
        bus.rd_en = 1'b0;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        check_output("read_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        single_vecs = '{'{addr: 9'd0,   data: 8'h00}, '{addr: 9'd255, data: 8'hFF},
                        '{addr: 9'd511, data: 8'hFF}, '{addr: 9'd1,   data: 8'h01},
                        '{addr: 9'd256, data: 8'h00}, '{addr: 9'd300, data: 8'h2C},
                        '{addr: 9'd128, data: 8'h80}};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.blk_done = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        check_output("reset_blk_ready", bus.blk_ready, 0);
        check_output("reset_blk_bank",  bus.blk_bank,  0);
        check_output("reset_rd_data",   bus.rd_data,   0);
        check_output("reset_rd_valid",  bus.rd_valid,  0);
        check_output("reset_overflow",  bus.overflow,  0);
        rst = 1'b0;
        tick();

        // Single incrementing block into bank 0.
        apply_stimulus(8'h00, BLOCK_BYTES - 1, 1'b1, 1'b0);
        check_output("single_not_ready_early", bus.blk_ready, 0);
        apply_stimulus(8'hFF, 1, 1'b0, 1'b0);
        check_output("single_ready", bus.blk_ready, 1);
        check_output("single_bank",  bus.blk_bank,  0);
        foreach (single_vecs[i]) read_byte(single_vecs[i].addr, single_vecs[i].data);
        drain();

        // Two blocks fill both banks, then a third arrives and must be dropped whole.
        do_reset();
        apply_stimulus(8'hA5, BLOCK_BYTES, 1'b0, 1'b0);
        apply_stimulus(8'h3C, BLOCK_BYTES, 1'b0, 1'b0);
        check_output("pp_ready",    bus.blk_ready, 1);
        check_output("pp_bank",     bus.blk_bank,  0);
        check_output("pp_overflow", bus.overflow,  0);
        read_byte(0, 8'hA5);
        read_byte(200, 8'hA5);
        read_byte(511, 8'hA5);
        drain();
        apply_stimulus(8'h77, 1, 1'b0, 1'b0);
        check_output("ovf_set", bus.overflow, 1);
        apply_stimulus(8'h77, 99, 1'b0, 1'b0);
        pulse_done();
        check_output("pp_done_bank",  bus.blk_bank,  1);
        check_output("pp_done_ready", bus.blk_ready, 1);
        read_byte(0, 8'h3C);
        read_byte(511, 8'h3C);
        drain();
        apply_stimulus(8'h77, BLOCK_BYTES - 100, 1'b0, 1'b0);
        apply_stimulus(8'h11, BLOCK_BYTES, 1'b0, 1'b0);
        check_output("ovf_ready",  bus.blk_ready, 1);
        check_output("ovf_bank",   bus.blk_bank,  1);
        check_output("ovf_sticky", bus.overflow,  1);
        read_byte(5, 8'h3C);
        read_byte(400, 8'h3C);
        drain();
        pulse_done();
        check_output("ovf_fourth_bank",  bus.blk_bank,  0);
        check_output("ovf_fourth_ready", bus.blk_ready, 1);
        read_byte(0, 8'h11);
        read_byte(100, 8'h11);
        read_byte(511, 8'h11);
        drain();
        pulse_done();
        check_output("pp_empty_ready", bus.blk_ready, 0);
        check_output("pp_empty_bank",  bus.blk_bank,  1);
        pulse_done();
        check_output("done_ignored_bank", bus.blk_bank, 1);

        // Abort mid-block; its coincident strobe must also be discarded.
        do_reset();
        apply_stimulus(8'hEE, 100, 1'b0, 1'b0);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        apply_stimulus(8'h42, BLOCK_BYTES - 1, 1'b0, 1'b0);
        check_output("abort_not_ready_early", bus.blk_ready, 0);
        apply_stimulus(8'h42, 1, 1'b0, 1'b0);
        check_output("abort_ready", bus.blk_ready, 1);
        check_output("abort_bank",  bus.blk_bank,  0);
        for (int a = 0; a < BLOCK_BYTES; a++) read_byte(a, 8'h42);
        drain();

        // Asynchronous reset partway through bank 1.
        do_reset();
        apply_stimulus(8'h5A, BLOCK_BYTES, 1'b0, 1'b0);
        apply_stimulus(8'h66, 300, 1'b0, 1'b0);
        read_byte(7, 8'h5A);
        drain();
        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst_ready",    bus.blk_ready, 0);
        check_output("async_rst_bank",     bus.blk_bank,  0);
        check_output("async_rst_rd_data",  bus.rd_data,   0);
        check_output("async_rst_rd_valid", bus.rd_valid,  0);
        check_output("async_rst_overflow", bus.overflow,  0);
        tick();
        rst = 1'b0;
        apply_stimulus(8'h24, BLOCK_BYTES - 1, 1'b0, 1'b0);
        check_output("post_rst_not_ready", bus.blk_ready, 0);
        apply_stimulus(8'h24, 1, 1'b0, 1'b0);
        check_output("post_rst_ready",    bus.blk_ready, 1);
        check_output("post_rst_bank",     bus.blk_bank,  0);
        check_output("post_rst_overflow", bus.overflow,  0);
        read_byte(0, 8'h24);
        read_byte(511, 8'h24);
        drain();

        // Final byte of bank 1 lands on the same edge as the release of bank 0.
        do_reset();
        apply_stimulus(8'h01, BLOCK_BYTES, 1'b0, 1'b0);
        apply_stimulus(8'h02, BLOCK_BYTES - 1, 1'b0, 1'b0);
        check_output("coinc_pre_bank", bus.blk_bank, 0);
        apply_stimulus(8'h02, 1, 1'b0, 1'b1);
        check_output("coinc_ready", bus.blk_ready, 1);
        check_output("coinc_bank",  bus.blk_bank,  1);
        read_byte(0, 8'h02);
        read_byte(511, 8'h02);
        drain();
        pulse_done();
        check_output("coinc_empty_ready", bus.blk_ready, 0);

        // Block start on a full bank coinciding with that bank's release: still dropped.
        do_reset();
        apply_stimulus(8'h0A, BLOCK_BYTES, 1'b0, 1'b0);
        apply_stimulus(8'h0B, BLOCK_BYTES, 1'b0, 1'b0);
        apply_stimulus(8'h0C, 1, 1'b0, 1'b1);
        check_output("race_overflow", bus.overflow,  1);
        check_output("race_bank",     bus.blk_bank,  1);
        check_output("race_ready",    bus.blk_ready, 1);
        apply_stimulus(8'h0C, BLOCK_BYTES - 1, 1'b0, 1'b0);
        apply_stimulus(8'h0D, BLOCK_BYTES, 1'b0, 1'b0);
        read_byte(0, 8'h0B);
        drain();
        pulse_done();
        check_output("race_next_bank",  bus.blk_bank,  0);
        check_output("race_next_ready", bus.blk_ready, 1);
        read_byte(0, 8'h0D);
        read_byte(511, 8'h0D);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
